// File: rtl/gpu_tex_cache.sv
// gpu_tex_cache: direct-mapped texture cache of 2^INDEX_W lines x 4 halfwords.
// A lookup is registered at the c0 edge and answered in c1. A single line fill
// runs through a small FSM that issues one VRAM read and collects two 32-bit beats.
module gpu_tex_cache #(
  parameter int INDEX_W = 8
) (
  input  logic        clk,
  input  logic        i_nrst,
  input  logic        requDataTex_c0,
  input  logic [18:0] adrTexReq_c0,
  output logic        TexHit_c1,
  output logic        TexMiss_c1,
  output logic [15:0] dataTex_c1,
  input  logic        requTexCacheUpdate_c1,
  input  logic [16:0] adrTexCacheUpdate_c0,
  output logic        updateTexCacheComplete,
  input  logic        i_invalidate,
  output logic        o_memReq,
  output logic [16:0] o_memAdr,
  input  logic        i_memAck,
  input  logic        i_memValid,
  input  logic [31:0] i_memData,
  output logic        o_busy
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 17 - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BEAT0,
    S_BEAT1,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [63:0]         r_data [LINES];
  logic                r_stale;
  logic [16:0]         r_fill_adr;
  logic [31:0]         r_beat0;
  logic [31:0]         r_beat1;
  logic                w_done;

  wire [INDEX_W-1:0] w_fill_idx = r_fill_adr[INDEX_W-1:0];
  wire [TAG_W-1:0]   w_fill_tag = r_fill_adr[16:INDEX_W];
  wire [INDEX_W-1:0] w_lk_idx   = adrTexReq_c0[INDEX_W+1:2];
  wire [TAG_W-1:0]   w_lk_tag   = adrTexReq_c0[18:INDEX_W+2];

  // A lookup landing on the edge that writes its own line sees the new line.
  wire               w_wr_match = w_done && (w_lk_idx == w_fill_idx);
  wire               w_lk_valid = !i_invalidate && (w_wr_match ? !r_stale : r_valid[w_lk_idx]);
  wire [TAG_W-1:0]   w_lk_tagq  = w_wr_match ? w_fill_tag : r_tag[w_lk_idx];
  wire [63:0]        w_lk_line  = w_wr_match ? {r_beat1, r_beat0} : r_data[w_lk_idx];
  wire               w_hit      = requDataTex_c0 && w_lk_valid && (w_lk_tagq == w_lk_tag);
  logic [15:0]       w_lk_half;

  assign o_memAdr = r_fill_adr;

  // Fill FSM state register.
  always_ff @(posedge clk or negedge i_nrst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_nrst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Fill FSM next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves w_next unassigned and infers a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (requTexCacheUpdate_c1) w_next = S_REQ;
      S_REQ:   if (i_memAck) w_next = i_memValid ? S_BEAT1 : S_BEAT0;
      S_BEAT0: if (i_memValid) w_next = S_BEAT1;
      S_BEAT1: if (i_memValid) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Fill FSM outputs, decoded from the current state only.
  always_comb begin
    o_memReq               = 1'b0;
    o_busy                 = (r_state != S_IDLE);
    updateTexCacheComplete = 1'b0;
    w_done                 = 1'b0;
    case (r_state)
      S_REQ:   o_memReq = 1'b1;
      S_DONE: begin
        updateTexCacheComplete = 1'b1;
        w_done                 = 1'b1;
      end
      default: ;
    endcase
  end

  // Fill datapath: latched line address, captured beats, stale flag and valid bits.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_fill_adr <= '0;
      r_beat0    <= '0;
      r_beat1    <= '0;
      r_stale    <= 1'b0;
      r_valid    <= '0;
    end else begin
      if (r_state == S_IDLE && requTexCacheUpdate_c1) r_fill_adr <= adrTexCacheUpdate_c0;
      if ((r_state == S_REQ && i_memAck && i_memValid) || (r_state == S_BEAT0 && i_memValid))
        r_beat0 <= i_memData;
      if (r_state == S_BEAT1 && i_memValid) r_beat1 <= i_memData;
      // An invalidate mid-fill poisons the line being fetched; cleared on return to IDLE.
      if (r_state != S_IDLE) begin
        if (w_next == S_IDLE)  r_stale <= 1'b0;
        else if (i_invalidate) r_stale <= 1'b1;
      end
      // Invalidate wins over a coincident line write.
      if (i_invalidate) r_valid <= '0;
      else if (w_done)  r_valid[w_fill_idx] <= !r_stale;
    end
  end

  // Tag and data arrays, written in the DONE cycle.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are deliberately not reset; valid bits alone gate their contents.
    if (w_done) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= {r_beat1, r_beat0};
    end
  end

  // Halfword select within the looked-up line.
  always_comb begin
    w_lk_half = w_lk_line[15:0];
    case (adrTexReq_c0[1:0])
      2'd0: w_lk_half = w_lk_line[15:0];
      2'd1: w_lk_half = w_lk_line[31:16];
      2'd2: w_lk_half = w_lk_line[47:32];
      2'd3: w_lk_half = w_lk_line[63:48];
      default: ;
    endcase
  end

  // Registered lookup result presented in c1.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      TexHit_c1  <= 1'b0;
      TexMiss_c1 <= 1'b0;
      dataTex_c1 <= '0;
    end else begin
      TexHit_c1  <= w_hit;
      TexMiss_c1 <= requDataTex_c0 && !w_hit;
      if (requDataTex_c0) dataTex_c1 <= w_lk_half;
    end
  end

endmodule

// File: tb/tb_gpu_tex_cache.sv
// tb_gpu_tex_cache: directed vectors for the documented scenarios, then random
// traffic compared against a line-level model of the cache and fill protocol.
module tb_gpu_tex_cache;

  logic        clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        requDataTex_c0 = 1'b0;
  logic [18:0] adrTexReq_c0 = '0;
  logic        TexHit_c1, TexMiss_c1;
  logic [15:0] dataTex_c1;
  logic        requTexCacheUpdate_c1 = 1'b0;
  logic [16:0] adrTexCacheUpdate_c0 = '0;
  logic        updateTexCacheComplete;
  logic        i_invalidate = 1'b0;
  logic        o_memReq;
  logic [16:0] o_memAdr;
  logic        i_memAck = 1'b0;
  logic        i_memValid = 1'b0;
  logic [31:0] i_memData = '0;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;

  gpu_tex_cache #(.INDEX_W(8)) dut (
    .clk(clk), .i_nrst(i_nrst),
    .requDataTex_c0(requDataTex_c0), .adrTexReq_c0(adrTexReq_c0),
    .TexHit_c1(TexHit_c1), .TexMiss_c1(TexMiss_c1), .dataTex_c1(dataTex_c1),
    .requTexCacheUpdate_c1(requTexCacheUpdate_c1), .adrTexCacheUpdate_c0(adrTexCacheUpdate_c0),
    .updateTexCacheComplete(updateTexCacheComplete), .i_invalidate(i_invalidate),
    .o_memReq(o_memReq), .o_memAdr(o_memAdr), .i_memAck(i_memAck),
    .i_memValid(i_memValid), .i_memData(i_memData), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_nrst = 1'b0;
    requDataTex_c0 = 1'b0; requTexCacheUpdate_c1 = 1'b0; i_invalidate = 1'b0;
    i_memAck = 1'b0; i_memValid = 1'b0;
    repeat (2) @(negedge clk);
    i_nrst = 1'b1;
    @(negedge clk);
  endtask

  // One lookup; results are visible to the caller on return.
  task automatic lookup(input logic [18:0] a);
    @(negedge clk);
    requDataTex_c0 = 1'b1; adrTexReq_c0 = a;
    @(negedge clk);
    requDataTex_c0 = 1'b0;
  endtask

  // Complete line fill acting as the VRAM agent, with optional invalidate in
  // BEAT0 and optional lookup issued in the DONE cycle.
  task automatic run_fill(input logic [16:0] ladr, input logic [31:0] b0, input logic [31:0] b1,
                          input int ack_dly, input bit inv_b0, input bit lk_done,
                          input logic [18:0] lk_adr, output int pulses,
                          output logic lk_hit, output logic [15:0] lk_data);
    pulses = 0; lk_hit = 1'b0; lk_data = '0;
    @(negedge clk);
    requTexCacheUpdate_c1 = 1'b1; adrTexCacheUpdate_c0 = ladr;
    @(negedge clk);
    requTexCacheUpdate_c1 = 1'b0;
    check("fill_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i <= ack_dly; i++) begin
      check("fill_memreq", 32'(o_memReq), 32'd1);
      check("fill_memadr", 32'(o_memAdr), 32'(ladr));
      if (i == ack_dly) i_memAck = 1'b1;
      @(negedge clk);
    end
    i_memAck = 1'b0;
    pulses += int'(updateTexCacheComplete);
    check("fill_memreq_drop", 32'(o_memReq), 32'd0);
    i_invalidate = inv_b0;
    @(negedge clk);
    i_invalidate = 1'b0; i_memValid = 1'b1; i_memData = b0;
    @(negedge clk);
    pulses += int'(updateTexCacheComplete);
    i_memData = b1;
    @(negedge clk);
    i_memValid = 1'b0;
    pulses += int'(updateTexCacheComplete);
    if (lk_done) begin
      requDataTex_c0 = 1'b1; adrTexReq_c0 = lk_adr;
    end
    @(negedge clk);
    requDataTex_c0 = 1'b0;
    lk_hit = TexHit_c1; lk_data = dataTex_c1;
    pulses += int'(updateTexCacheComplete);
    check("fill_idle", 32'(o_busy), 32'd0);
    repeat (2) begin
      @(negedge clk);
      pulses += int'(updateTexCacheComplete);
    end
  endtask

  typedef struct {
    logic [18:0] adr;
    logic        hit;
    logic [15:0] data;
  } vec_t;

  // Address pool keeps random traffic colliding on a few lines.
  logic [8:0] tag_pool [4] = '{9'h048, 9'h014, 9'h1FF, 9'h000};
  logic [7:0] idx_pool [4] = '{8'hD1, 8'hD2, 8'h00, 8'hFF};

  function automatic logic [16:0] pick_line();
    return {tag_pool[$urandom_range(0, 3)], idx_pool[$urandom_range(0, 3)]};
  endfunction

  // Reference model: cache contents per index plus fill progress.
  bit          m_valid [256];
  logic [8:0]  m_tag   [256];
  logic [63:0] m_line  [256];
  bit          m_busy, m_acked, m_done, m_stale;
  int          m_beats;
  logic [16:0] m_adr;
  logic [31:0] m_b [2];
  bit          e_hit, e_miss;
  logic [15:0] e_data;

  initial begin
    vec_t vecs[7];
    int   pulses;
    logic h;
    logic [15:0] d;

    vecs[0] = '{19'h12344, 1'b1, 16'hAAAA};
    vecs[1] = '{19'h12345, 1'b1, 16'hBBBB};
    vecs[2] = '{19'h12346, 1'b1, 16'hCCCC};
    vecs[3] = '{19'h12347, 1'b1, 16'hDDDD};
    vecs[4] = '{19'h12348, 1'b0, 16'h0000};
    vecs[5] = '{19'h52344, 1'b0, 16'h0000};
    vecs[6] = '{19'h02345, 1'b0, 16'h0000};

    // Reset values.
    do_reset();
    check("rst_hit", 32'(TexHit_c1), 32'd0);
    check("rst_miss", 32'(TexMiss_c1), 32'd0);
    check("rst_data", 32'(dataTex_c1), 32'd0);
    check("rst_complete", 32'(updateTexCacheComplete), 32'd0);
    check("rst_memreq", 32'(o_memReq), 32'd0);
    check("rst_memadr", 32'(o_memAdr), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);

    // First lookup after reset misses.
    lookup(19'h12345);
    check("cold_miss", 32'(TexMiss_c1), 32'd1);
    check("cold_hit", 32'(TexHit_c1), 32'd0);

    // Fill 0x12345's line with a lookup for halfword 3 in the DONE cycle.
    run_fill(17'h048D1, 32'hBBBBAAAA, 32'hDDDDCCCC, 3, 1'b0, 1'b1, 19'h12347, pulses, h, d);
    check("fill1_pulses", 32'(pulses), 32'd1);
    check("done_lookup_hit", 32'(h), 32'd1);
    check("done_lookup_data", 32'(d), 32'h0000DDDD);

    // Table of lookups against the filled line.
    for (int i = 0; i < 7; i++) begin
      lookup(vecs[i].adr);
      check($sformatf("vec%0d_hit", i), 32'(TexHit_c1), 32'(vecs[i].hit));
      check($sformatf("vec%0d_miss", i), 32'(TexMiss_c1), 32'(!vecs[i].hit));
      if (vecs[i].hit) check($sformatf("vec%0d_data", i), 32'(dataTex_c1), 32'(vecs[i].data));
    end

    // Conflict refill evicts the old tag.
    run_fill(17'h148D1, 32'h22221111, 32'h44443333, 0, 1'b0, 1'b0, 19'h0, pulses, h, d);
    check("fill2_pulses", 32'(pulses), 32'd1);
    lookup(19'h12344);
    check("evicted_miss", 32'(TexMiss_c1), 32'd1);
    lookup(19'h52346);
    check("refill_hit", 32'(TexHit_c1), 32'd1);
    check("refill_data", 32'(dataTex_c1), 32'h00003333);

    // Invalidate during BEAT0: pulse still emitted, line left invalid.
    run_fill(17'h048D1, 32'hBBBBAAAA, 32'hDDDDCCCC, 1, 1'b1, 1'b0, 19'h0, pulses, h, d);
    check("stale_pulses", 32'(pulses), 32'd1);
    lookup(19'h12345);
    check("stale_miss", 32'(TexMiss_c1), 32'd1);
    lookup(19'h52344);
    check("inv_other_miss", 32'(TexMiss_c1), 32'd1);
    run_fill(17'h048D1, 32'hBBBBAAAA, 32'hDDDDCCCC, 2, 1'b0, 1'b0, 19'h0, pulses, h, d);
    check("refetch_pulses", 32'(pulses), 32'd1);
    lookup(19'h12345);
    check("refetch_hit", 32'(TexHit_c1), 32'd1);
    check("refetch_data", 32'(dataTex_c1), 32'h0000BBBB);

    // Reset in BEAT1 abandons the fill.
    @(negedge clk);
    requTexCacheUpdate_c1 = 1'b1; adrTexCacheUpdate_c0 = 17'h00123;
    @(negedge clk);
    requTexCacheUpdate_c1 = 1'b0; i_memAck = 1'b1;
    @(negedge clk);
    i_memAck = 1'b0; i_memValid = 1'b1; i_memData = 32'h01010101;
    @(negedge clk);
    i_memValid = 1'b0;
    check("b1_busy_before", 32'(o_busy), 32'd1);
    i_nrst = 1'b0;
    #1;
    check("b1_rst_busy", 32'(o_busy), 32'd0);
    check("b1_rst_complete", 32'(updateTexCacheComplete), 32'd0);
    @(negedge clk);
    i_nrst = 1'b1; i_memValid = 1'b1; i_memData = 32'h02020202;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      pulses += int'(updateTexCacheComplete) + int'(o_busy) + int'(o_memReq);
    end
    i_memValid = 1'b0;
    check("b1_post_quiet", 32'(pulses), 32'd0);
    lookup(19'h0048C);
    check("b1_abandoned_miss", 32'(TexMiss_c1), 32'd1);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    m_busy = 0; m_acked = 0; m_done = 0; m_stale = 0; m_beats = 0; m_adr = '0;
    e_hit = 0; e_miss = 0; e_data = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit          req, freq, ack, vld, inv;
      logic [18:0] a;
      logic [16:0] fl;
      logic [31:0] md;
      int          ix;
      @(negedge clk);
      check("rnd_busy", 32'(o_busy), 32'(m_busy));
      check("rnd_memreq", 32'(o_memReq), 32'(m_busy && !m_acked));
      if (m_busy && !m_acked) check("rnd_memadr", 32'(o_memAdr), 32'(m_adr));
      check("rnd_complete", 32'(updateTexCacheComplete), 32'(m_done));
      check("rnd_hit", 32'(TexHit_c1), 32'(e_hit));
      check("rnd_miss", 32'(TexMiss_c1), 32'(e_miss));
      if (e_hit) check("rnd_data", 32'(dataTex_c1), 32'(e_data));

      req  = ($urandom_range(0, 1) == 1);
      a    = {pick_line(), 2'($urandom_range(0, 3))};
      freq = ($urandom_range(0, 3) == 0);
      fl   = pick_line();
      ack  = ($urandom_range(0, 2) == 0);
      vld  = ($urandom_range(0, 1) == 1);
      md   = $urandom;
      inv  = ($urandom_range(0, 39) == 0);
      requDataTex_c0 = req; adrTexReq_c0 = a;
      requTexCacheUpdate_c1 = freq; adrTexCacheUpdate_c0 = fl;
      i_memAck = ack; i_memValid = vld; i_memData = md; i_invalidate = inv;

      // Line write of a finished fill, then invalidate, then the lookup sees the result.
      if (m_done) begin
        ix = int'(m_adr[7:0]);
        m_line[ix]  = {m_b[1], m_b[0]};
        m_tag[ix]   = m_adr[16:8];
        m_valid[ix] = !m_stale;
      end
      if (inv) for (int k = 0; k < 256; k++) m_valid[k] = 1'b0;
      ix     = int'(a[9:2]);
      e_hit  = req && m_valid[ix] && (m_tag[ix] == a[18:10]);
      e_miss = req && !e_hit;
      e_data = m_line[ix][int'(a[1:0]) * 16 +: 16];

      // Fill progress: request, acknowledge, two beats, one completion cycle.
      if (inv && m_busy) m_stale = 1'b1;
      if (m_done) begin
        m_busy = 0; m_done = 0; m_stale = 0;
      end else if (!m_busy) begin
        if (freq) begin
          m_busy = 1; m_acked = 0; m_beats = 0; m_adr = fl;
        end
      end else if (!m_acked) begin
        if (ack) begin
          m_acked = 1;
          if (vld) begin
            m_b[0] = md; m_beats = 1;
          end
        end
      end else if (vld) begin
        m_b[m_beats] = md;
        m_beats++;
        if (m_beats == 2) m_done = 1;
      end
    end
    @(negedge clk);
    requDataTex_c0 = 0; requTexCacheUpdate_c1 = 0; i_memAck = 0; i_memValid = 0; i_invalidate = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
